// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial MSB-first pattern generator with repeat count and zero-fill gaps
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t             state, state_n;
    logic [PAT_W-1:0]   pat_q, pat_n;
    logic [CNT_W-1:0]   rep_left, rep_n;
    logic [GAP_W-1:0]   gap_q, gapq_n;
    logic [GAP_W-1:0]   gap_left, gapl_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               out_n, valid_n, busy_n, done_n;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= S_IDLE;
            pat_q     <= '0;
            rep_left  <= '0;
            gap_q     <= '0;
            gap_left  <= '0;
            idx       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            pat_q     <= pat_n;
            rep_left  <= rep_n;
            gap_q     <= gapq_n;
            gap_left  <= gapl_n;
            idx       <= idx_n;
            out       <= out_n;
            out_valid <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // rep_left counts repetitions still owed after the one on the wire;
    // gap_left counts fill bits still owed after the one on the wire.
    always_comb begin
        state_n = state;
        pat_n   = pat_q;
        rep_n   = rep_left;
        gapq_n  = gap_q;
        gapl_n  = gap_left;
        idx_n   = idx;
        out_n   = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pat_n  = pattern;
                    gapq_n = gap;
                    if (repeat_cnt != '0) begin
                        rep_n   = repeat_cnt - 1'b1;
                        idx_n   = IDX_MAX;
                        out_n   = pattern[PAT_W-1];
                        valid_n = 1'b1;
                        busy_n  = 1'b1;
                        state_n = S_SEND;
                    end else begin
                        rep_n   = '0;
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end
                end
            end
            S_SEND: begin
                valid_n = 1'b1;
                busy_n  = 1'b1;
                if (idx != '0) begin
                    idx_n = idx - 1'b1;
                    out_n = pat_q[idx_n];
                end else if (rep_left != '0) begin
                    rep_n = rep_left - 1'b1;
                    if (gap_q != '0) begin
                        gapl_n  = gap_q - 1'b1;
                        state_n = S_GAP;
                    end else begin
                        idx_n = IDX_MAX;
                        out_n = pat_q[PAT_W-1];
                    end
                end else begin
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_GAP: begin
                valid_n = 1'b1;
                busy_n  = 1'b1;
                if (gap_left != '0) begin
                    gapl_n = gap_left - 1'b1;
                end else begin
                    idx_n   = IDX_MAX;
                    out_n   = pat_q[PAT_W-1];
                    state_n = S_SEND;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed self-checking bench for seq_pattern_gen
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       clear;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] repeat_cnt;
    logic [2:0] gap;
    logic       out, out_valid, busy, done;

    int checks = 0;
    int errors = 0;

    seq_pattern_gen #(.PAT_W(4), .CNT_W(4), .GAP_W(3)) dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap        (gap),
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out"}, out, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Called at the falling edge of cycle 1 after acceptance; returns at the done cycle.
    task automatic check_stream(input string tag, input logic [31:0] bits, input int n, input int inj);
        for (int i = 1; i <= n; i++) begin
            check($sformatf("%s_out%0d", tag, i), out, bits[n-i]);
            check($sformatf("%s_valid%0d", tag, i), out_valid, 1);
            check($sformatf("%s_busy%0d", tag, i), busy, 1);
            check($sformatf("%s_done%0d", tag, i), done, 0);
            if (i == inj) begin
                start   = 1'b1;
                pattern = 4'b0000;
            end else if (i == inj + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_done_end"}, done, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_valid_end"}, out_valid, 0);
        check({tag, "_out_end"}, out, 0);
    endtask

    task automatic launch(input logic [3:0] p, input logic [3:0] r, input logic [2:0] g);
        pattern    = p;
        repeat_cnt = r;
        gap        = g;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int vcnt;
        clear = 1'b1; start = 1'b0; pattern = '0; repeat_cnt = '0; gap = '0;
        @(negedge clk);
        check_idle("rst_in");
        clear = 1'b0;
        @(negedge clk); check_idle("rst_c1");
        @(negedge clk); check_idle("rst_c2");

        launch(4'b1011, 4'd2, 3'd0);
        check_stream("basic", 32'b10111011, 8, 0);
        @(negedge clk); check_idle("basic_after");

        launch(4'b1011, 4'd3, 3'd2);
        check_stream("gapfill", 32'b1011001011001011, 16, 0);
        @(negedge clk); check_idle("gapfill_after");

        launch(4'b1111, 4'd0, 3'd1);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_valid", out_valid, 0);
        @(negedge clk); check_idle("zero_after");
        @(negedge clk); check_idle("zero_after2");

        launch(4'b1011, 4'd2, 3'd0);
        check_stream("busyprot", 32'b10111011, 8, 3);
        pattern = 4'b0110; repeat_cnt = 4'd1; gap = 3'd0; start = 1'b1;
        @(negedge clk);
        check_idle("done_start_ignored");
        @(negedge clk);
        start = 1'b0;
        check_stream("relaunch", 32'b0110, 4, 0);
        @(negedge clk); check_idle("relaunch_after");

        launch(4'b1101, 4'd2, 3'd1);
        check("abort_pre_out", out, 1);
        check("abort_pre_valid", out_valid, 1);
        #2 clear = 1'b1;
        #1;
        check_idle("abort_now");
        #1 clear = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("abort_quiet_valid%0d", i), out_valid, 0);
            check($sformatf("abort_quiet_done%0d", i), done, 0);
        end
        launch(4'b1011, 4'd1, 3'd3);
        check_stream("post_abort", 32'b1011, 4, 0);
        @(negedge clk); check_idle("post_abort_after");

        launch(4'b1001, 4'd15, 3'd7);
        vcnt = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (out_valid) vcnt++;
            @(negedge clk);
        end
        check("max_done", done, 1);
        check("max_len", vcnt, 158);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
